// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one shift-add or restoring shift-subtract step per cycle over a
// shared 2*WIDTH accumulator, followed by a sign-correction cycle and a one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_e      state_q;
  muldiv_op_e         op_q;
  logic               sign_a_q, sign_b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               is_div;
  logic               sign_a_in, sign_b_in;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               dbz_d;
  logic [WIDTH-1:0]   hi_d, lo_d;

  assign is_div = op_q[1];

  // NOTE: every signal assigned here gets a value on all paths, so no latch can be inferred.
  always_comb begin
    sign_a_in = ~op[0] & src1[WIDTH-1];
    sign_b_in = ~op[0] & src2[WIDTH-1];
    abs_a_in  = sign_a_in ? -src1 : src1;
    abs_b_in  = sign_b_in ? -src2 : src2;

    // Multiply consumes the multiplier from the low half, LSB first.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & b_q};
    // Divide shifts the next dividend bit into the partial remainder; diff[WIDTH] is the borrow.
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, b_q};

    if (is_div) begin
      acc_step = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With a zero divisor the remainder ends up as |src1|; re-applying the sign restores src1.
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    dbz_d    = is_div & (b_q == '0);

    if (is_div) begin
      hi_d = rem_fix;
      lo_d = dbz_d ? '1 : quot_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  // NOTE: the datapath registers are reset along with the FSM so an aborted op leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= muldiv_op_e'(op);
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            b_q      <= abs_b_in;
            acc_q    <= {{WIDTH{1'b0}}, abs_a_in};
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= dbz_d;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at WIDTH=32 plus a reference-model sweep at WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] s1_32 = '0, s2_32 = '0;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  s1_8 = '0, s2_8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .src1(s1_32), .src2(s2_32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src1(s1_8), .src2(s2_8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one op on the 32-bit unit, scramble inputs after acceptance, and wait for done.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy32 && guard < 100) begin @(negedge clk); guard++; end
    op32 = op; s1_32 = a; s2_32 = b; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; op32 = ~op; s1_32 = ~a; s2_32 = b + 32'd5;
    lat = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done32) begin lat = n; break; end
    end
    h = hi32; l = lo32; z = dbz32;
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] h, output logic [7:0] l, output logic z,
                      output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 40) begin @(negedge clk); guard++; end
    op8 = op; s1_8 = a; s2_8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; op8 = ~op; s1_8 = ~a; s2_8 = ~b;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done8) begin lat = n; break; end
    end
    h = hi8; l = lo8; z = dbz8;
  endtask

  task automatic model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] h, output logic [7:0] l, output logic z);
    logic signed [15:0] ps;
    logic [15:0]        pu;
    int                 sa, sb;
    z = 1'b0;
    case (op)
      MULT:  begin ps = $signed(a) * $signed(b); h = ps[15:8]; l = ps[7:0]; end
      MULTU: begin pu = {8'h00, a} * {8'h00, b}; h = pu[15:8]; l = pu[7:0]; end
      DIV: begin
        if (b == 8'h00) begin l = 8'hFF; h = a; z = 1'b1; end
        else if (a == 8'h80 && b == 8'hFF) begin l = 8'h80; h = 8'h00; end
        else begin
          sa = $signed(a); sb = $signed(b);
          l = 8'(sa / sb); h = 8'(sa % sb);
        end
      end
      default: begin
        if (b == 8'h00) begin l = 8'hFF; h = a; z = 1'b1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    logic        exp_dbz;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] h, l;
    logic        z;
    logic [7:0]  h8, l8, eh8, el8, a8, b8;
    logic [1:0]  o8;
    logic        z8, ez8;
    int          lat, dones, guard;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy32, 1'b0);
    check("rst_done", done32, 1'b0);
    check("rst_hi", hi32, 32'h0);
    check("rst_lo", lo32, 32'h0);
    check("rst_dbz", dbz32, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"});
    vecs.push_back('{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7"});
    vecs.push_back('{MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, "mult_neg_neg"});
    vecs.push_back('{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minmin"});
    vecs.push_back('{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7by2"});
    vecs.push_back('{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7byneg2"});
    vecs.push_back('{DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, "divu_by0"});
    vecs.push_back('{DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, "div_neg_by0"});
    vecs.push_back('{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"});
    vecs.push_back('{DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, "divu_big"});

    foreach (vecs[i]) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, h, l, z, lat);
      check({vecs[i].tag, "_hi"}, h, vecs[i].exp_hi);
      check({vecs[i].tag, "_lo"}, l, vecs[i].exp_lo);
      check({vecs[i].tag, "_dbz"}, z, vecs[i].exp_dbz);
      check({vecs[i].tag, "_lat"}, lat, 33);
    end

    repeat (5) @(negedge clk);
    check("hold_hi", hi32, 32'h0000FFFF);
    check("hold_lo", lo32, 32'h0000FFFF);

    // start pulses while busy must not disturb the op in flight.
    op32 = DIVU; s1_32 = 32'd10; s2_32 = 32'd3; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    dones = 0; h = '0; l = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done32) begin dones++; h = hi32; l = lo32; end
      start32 = (n == 4 || n == 9);
      if (start32) begin op32 = MULTU; s1_32 = 32'd50; s2_32 = 32'd7; end
    end
    start32 = 1'b0;
    check("busy_start_dones", dones, 1);
    check("busy_start_lo", l, 32'd3);
    check("busy_start_hi", h, 32'd1);
    check("busy_start_idle", busy32, 1'b0);

    // Reset in the middle of CALC aborts the op.
    op32 = MULTU; s1_32 = 32'hFFFFFFFF; s2_32 = 32'd12345; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy32, 1'b0);
    check("abort_hi", hi32, 32'h0);
    check("abort_lo", lo32, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done32) dones++;
    end
    check("abort_no_done", dones, 0);
    run32(MULTU, 32'd6, 32'd7, h, l, z, lat);
    check("after_abort_hi", h, 32'h0);
    check("after_abort_lo", l, 32'd42);
    check("after_abort_lat", lat, 33);

    for (int i = 0; i < 1000; i++) begin
      o8 = 2'($urandom_range(0, 3));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       b8 = 8'h00;
        1:       begin a8 = 8'h80; b8 = 8'hFF; end
        default: ;
      endcase
      model8(o8, a8, b8, eh8, el8, ez8);
      run8(o8, a8, b8, h8, l8, z8, lat);
      check($sformatf("w8_%0d_hi", i), h8, eh8);
      check($sformatf("w8_%0d_lo", i), l8, el8);
      check($sformatf("w8_%0d_dbz", i), z8, ez8);
      check($sformatf("w8_%0d_lat", i), lat, 9);
    end

    guard = 0;
    while (busy8 && guard < 20) begin @(negedge clk); guard++; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result-half width, legal range 4 to 64.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: request an operation; sampled only in IDLE.
REQ-005 Port op, input, 2: operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port src1, input, WIDTH: multiplicand or dividend.
REQ-007 Port src2, input, WIDTH: multiplier or divisor.
REQ-008 Port busy, output, 1: high in every state except IDLE.
REQ-009 Port done, output, 1: one-cycle pulse marking hi/lo valid.
REQ-010 Port hi, output, WIDTH: MULT upper product half; DIV remainder.
REQ-011 Port lo, output, WIDTH: MULT lower product half; DIV quotient.
REQ-012 Port div_by_zero, output, 1: valid with done; high when a DIV/DIVU divisor is zero.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-014 IDLE with start=1 SHALL latch op, src1, src2 and operand signs, take absolute values for signed ops, clear the iteration counter and enter CALC.
REQ-015 CALC SHALL run exactly WIDTH iterations: shift-add for multiply, restoring shift-subtract for divide; counter is $clog2(WIDTH+1) bits.
REQ-016 After the WIDTH-th iteration, FIX SHALL apply sign correction: product negated over 2*WIDTH bits when signs differ; quotient negated when signs differ; remainder takes the dividend's sign.
REQ-017 FIX SHALL load hi/lo and div_by_zero and enter DONE; done SHALL be high only in DONE; DONE returns to IDLE on the next edge.
REQ-018 Latency: with start accepted on edge k, done SHALL be high in the cycle following edge k+WIDTH+1.
REQ-019 start while busy=1 SHALL be ignored and have no effect on the operation in flight.
REQ-020 start in DONE SHALL be ignored; back-to-back ops need start in the following IDLE cycle, giving a throughput of one op per WIDTH+3 cycles.
REQ-021 src1, src2 and op MAY change after the accept edge; results SHALL depend only on the latched values.
REQ-022 Divide by zero: lo SHALL be all ones, hi SHALL equal src1 unmodified, div_by_zero=1, with the same latency as a normal op.
REQ-023 Signed overflow (DIV with most-negative / -1): lo SHALL be the most-negative value, hi=0, div_by_zero=0.
REQ-024 hi, lo and div_by_zero SHALL hold their values from the last completed op until the next FIX.
REQ-025 For multiply ops, div_by_zero SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE and set busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear the counter and datapath registers.
REQ-027 Reset asserted mid-CALC SHALL abort the op with no done pulse; the first start after release SHALL behave normally.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op enum (MULT, MULTU, DIV, DIVU) and the state enum.
REQ-029 muldiv_unit SHALL be a single module with no sub-module; the 2*WIDTH accumulator is shared between multiply and divide.

Verification (WIDTH=32 unless stated)
REQ-030 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the accept edge.
REQ-031 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 start pulsed at cycles 5 and 10 of a DIVU 10/3 -> single result lo=3, hi=1, single done pulse.
REQ-034 rst_n low at iteration 12 of MULTU, then MULTU 6*7 -> no done for the aborted op, then hi=0, lo=42.
REQ-035 WIDTH=8: random ops checked against a reference model for 1000 ops; done 9 cycles after each accept edge.
